grf_wb_arbiter: RTL and testbench
=================================

Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port (A3/WD/WE plus trace PC) between two writeback sources.
- Source 1 is the main pipeline writeback (fixed priority, never back-pressured).
- Source 2 is the multi-cycle mult/div unit (MDU), which hands over results via valid/ready through a small FIFO.
- Keeps a per-register pending scoreboard from MDU issue to GRF commit and drives the decode-stage stall.

Parameters:
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data and PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- pl_we  in  1  pipeline writeback enable.
- pl_addr  in  ADDR_W  pipeline destination register.
- pl_wd  in  DATA_W  pipeline write data.
- pl_pc  in  DATA_W  PC of the writing instruction.
- md_issue  in  1  MDU accepted an op this cycle.
- md_issue_addr  in  ADDR_W  destination register of that op.
- md_valid  in  1  MDU result available.
- md_ready  out  1  arbiter accepts the MDU result.
- md_addr  in  ADDR_W  MDU result destination.
- md_wd  in  DATA_W  MDU result data.
- md_pc  in  DATA_W  PC of the MDU op.
- grf_we  out  1  GRF write enable.
- grf_a3  out  ADDR_W  GRF write address.
- grf_wd  out  DATA_W  GRF write data.
- grf_pc  out  DATA_W  PC for the GRF write trace.
- chk_a1  in  ADDR_W  decode rs.
- chk_a2  in  ADDR_W  decode rt.
- chk_a3  in  ADDR_W  decode destination (WAW check).
- stall  out  1  decode must hold.
- pending  out  32  scoreboard bit vector.

Behaviour:
- Reset (async, active-low):
  - FIFO empty, count 0, pending = 0.
  - grf_we/grf_a3/grf_wd/grf_pc = 0.
  - md_ready = 0 while reset is asserted.
- md_ready = !full (combinational).
- MDU push on md_valid && md_ready. A push with md_addr == 0 is accepted but not stored.
- Output stage is registered; one-cycle latency from selection to grf_* outputs. Selection at each edge:
  - pl_we && pl_addr != 0: drive pl fields. The FIFO does not pop.
  - Else FIFO non-empty: pop the head and drive its fields.
  - Else: grf_we = 0; grf_a3/grf_wd/grf_pc hold their last value.
- pl_we with pl_addr == 0 counts as idle, so the FIFO may pop.
- Pipeline priority is absolute. Continuous pipeline writes may fill the FIFO and hold md_ready low indefinitely; this is allowed.
- Push and pop in the same cycle with the FIFO full:
  - Not possible, because md_ready is computed from the pre-edge count.
  - With the FIFO neither empty nor full, simultaneous push and pop leave the count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. Data order is strictly FIFO.
- Scoreboard:
  - md_issue with md_issue_addr != 0 sets pending[addr] at the edge.
  - A pop clears pending[head.addr] at the same edge.
  - Set and clear on the same address in the same cycle: set wins.
  - md_issue to an address already pending is illegal; the bench asserts on it.
  - pending[0] is always 0.
- stall is combinational. It is high if any nonzero chk_aX has pending set, or matches grf_a3 while grf_we is high (write in flight, not yet committed). chk_aX == 0 never stalls.
- grf_wd/grf_pc are passed through unmodified; the arbiter performs no arithmetic on data.
- Reset mid-operation: FIFO contents and pending bits are discarded, and no GRF write is emitted afterwards.

Decomposition:
- Package grf_pkg holds:
  - ADDR_W, DATA_W, REG_ZERO = 0.
  - typedef wb_entry_t {addr, wd, pc}.
  - An enum for the output source {SRC_NONE, SRC_PL, SRC_MD}.
- One sub-module, wb_fifo: parameterised FIFO of wb_entry_t with push/pop/full/empty/count.
- Output mux and scoreboard live in the top.

Test Plan:
- Pipeline-only write: pl_we=1, pl_addr=8, pl_wd=0x1234, pl_pc=0x3000 → next cycle grf_we=1, grf_a3=8, grf_wd=0x1234, grf_pc=0x3000; md_ready stays 1.
- MDU through idle port:
  - md_issue addr 9 → pending[9]=1.
  - With chk_a1=9, stall=1.
  - md_valid addr 9, wd 0xCAFE → grf write of reg 9 two cycles after the push.
  - pending[9] clears at the pop; stall stays high through the in-flight cycle, then drops.
- Contention:
  - pl_we held for 4 cycles, with MDU pushes to 10, then 11, then a third.
  - After 2 pushes md_ready=0 and the third is held.
  - When pl_we drops, writes to 10 and then 11 appear in order, then the third.
- Zero register:
  - pl_addr=0 with the FIFO non-empty → FIFO pops that cycle.
  - md push with addr 0 is accepted with no grf write.
  - chk_a1=0 never stalls.
- Async reset mid-operation: FIFO holds 2 entries and pending = {10,11}; assert reset between edges → outputs 0 immediately, pending = 0, and no writes after release.
- WAW: md_issue addr 12 pending, chk_a3=12 → stall=1 until commit.

Source files
------------

// File: rtl/grf_pkg.sv
// grf_pkg: shared types and constants for the GRF writeback arbiter.
//   ADDR_W / DATA_W : register address and data/PC widths (the entry struct
//                     depends on them, so they live here, not on the modules)
//   REG_ZERO        : hard-wired zero register, never written or tracked
//   wb_entry_t      : one writeback {addr, wd, pc}
//   wb_src_e        : which source drives the GRF write port this cycle
//   reg_hazard()    : decode-side hazard test for a single source register
package grf_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 32;
   localparam int NUM_REGS = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] pc;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_PL   = 2'd1,
      SRC_MD   = 2'd2
   } wb_src_e;

   // A register is hazardous while an MDU result for it is outstanding, or
   // while a write to it sits in the output register (not yet in the GRF).
   // Register 0 is never hazardous.
   function automatic logic reg_hazard(input logic [ADDR_W-1:0]   a,
                                       input logic [NUM_REGS-1:0] pend,
                                       input logic                we,
                                       input logic [ADDR_W-1:0]   wa);
      return (a != REG_ZERO) && (pend[a] || (we && (wa == a)));
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of wb_entry_t used to buffer MDU results.
//   clk, reset   : clock, asynchronous active-low reset
//   push, push_data : write one entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   head         : current head entry (valid when !empty)
//   full, empty, count : occupancy status from the registered count
module wb_fifo
   import grf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  wb_entry_t                push_data,
   input  logic                     pop,
   output wb_entry_t                head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
   // increment wraps modulo DEPTH on its own.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the single GRF write port between the main pipeline
// writeback (absolute priority) and the multi-cycle MDU (buffered in a FIFO),
// and tracks per-register pending MDU results to drive the decode stall.
//   clk, reset            : clock, asynchronous active-low reset
//   pl_we/pl_addr/pl_wd/pl_pc : pipeline writeback
//   md_issue/md_issue_addr    : MDU accepted an op for this destination
//   md_valid/md_ready/md_addr/md_wd/md_pc : MDU result handshake
//   grf_we/grf_a3/grf_wd/grf_pc : registered GRF write port and trace PC
//   chk_a1/chk_a2/chk_a3  : decode rs, rt and destination for hazard check
//   stall                 : decode must hold this cycle
//   pending               : per-register outstanding-MDU-result bit vector
module grf_wb_arbiter
   import grf_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pl_we,
   input  logic [ADDR_W-1:0]   pl_addr,
   input  logic [DATA_W-1:0]   pl_wd,
   input  logic [DATA_W-1:0]   pl_pc,
   input  logic                md_issue,
   input  logic [ADDR_W-1:0]   md_issue_addr,
   input  logic                md_valid,
   output logic                md_ready,
   input  logic [ADDR_W-1:0]   md_addr,
   input  logic [DATA_W-1:0]   md_wd,
   input  logic [DATA_W-1:0]   md_pc,
   output logic                grf_we,
   output logic [ADDR_W-1:0]   grf_a3,
   output logic [DATA_W-1:0]   grf_wd,
   output logic [DATA_W-1:0]   grf_pc,
   input  logic [ADDR_W-1:0]   chk_a1,
   input  logic [ADDR_W-1:0]   chk_a2,
   input  logic [ADDR_W-1:0]   chk_a3,
   output logic                stall,
   output logic [NUM_REGS-1:0] pending
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   wb_entry_t           md_entry;
   wb_entry_t           fifo_head;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic                md_accept;
   logic                pl_live;
   wb_src_e             src;

   logic                grf_we_q, grf_we_d;
   logic [ADDR_W-1:0]   grf_a3_q, grf_a3_d;
   logic [DATA_W-1:0]   grf_wd_q, grf_wd_d;
   logic [DATA_W-1:0]   grf_pc_q, grf_pc_d;
   logic [NUM_REGS-1:0] pending_q, pending_d;

   // MDU handshake: a result transfers on a rising edge where md_valid and
   // md_ready are both high. md_ready depends only on the registered FIFO
   // count (never on md_valid), so a full FIFO can never see push and pop
   // collide. The MDU must hold its fields stable while md_valid && !md_ready.
   assign md_ready  = reset && !fifo_full;
   assign md_accept = md_valid && md_ready;
   // A result for register 0 completes the handshake but is dropped.
   assign fifo_push = md_accept && (md_addr != REG_ZERO);
   assign md_entry  = '{addr: md_addr, wd: md_wd, pc: md_pc};

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (md_entry),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // A pipeline write to register 0 is treated as idle so the FIFO can drain.
   assign pl_live = pl_we && (pl_addr != REG_ZERO);

   always_comb begin
      src = SRC_NONE;
      if (pl_live) begin
         src = SRC_PL;
      end else if (!fifo_empty) begin
         src = SRC_MD;
      end
   end

   assign fifo_pop = (src == SRC_MD);

   // Output register: address/data/PC hold their last value on idle cycles.
   always_comb begin
      grf_we_d = 1'b0;
      grf_a3_d = grf_a3_q;
      grf_wd_d = grf_wd_q;
      grf_pc_d = grf_pc_q;
      case (src)
         SRC_PL: begin
            grf_we_d = 1'b1;
            grf_a3_d = pl_addr;
            grf_wd_d = pl_wd;
            grf_pc_d = pl_pc;
         end
         SRC_MD: begin
            grf_we_d = 1'b1;
            grf_a3_d = fifo_head.addr;
            grf_wd_d = fifo_head.wd;
            grf_pc_d = fifo_head.pc;
         end
         default: begin
            grf_we_d = 1'b0;
         end
      endcase
   end

   // Scoreboard: the clear from a pop is applied first so that a new issue
   // to the same register in the same cycle wins.
   always_comb begin
      pending_d = pending_q;
      if (fifo_pop) begin
         pending_d[fifo_head.addr] = 1'b0;
      end
      if (md_issue && (md_issue_addr != REG_ZERO)) begin
         pending_d[md_issue_addr] = 1'b1;
      end
      pending_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grf_we_q  <= 1'b0;
         grf_a3_q  <= '0;
         grf_wd_q  <= '0;
         grf_pc_q  <= '0;
         pending_q <= '0;
      end else begin
         grf_we_q  <= grf_we_d;
         grf_a3_q  <= grf_a3_d;
         grf_wd_q  <= grf_wd_d;
         grf_pc_q  <= grf_pc_d;
         pending_q <= pending_d;
      end
   end

   assign grf_we  = grf_we_q;
   assign grf_a3  = grf_a3_q;
   assign grf_wd  = grf_wd_q;
   assign grf_pc  = grf_pc_q;
   assign pending = pending_q;

   // chk_a3 covers WAW: a younger write must not overtake an outstanding one.
   assign stall = reg_hazard(chk_a1, pending_q, grf_we_q, grf_a3_q) ||
                  reg_hazard(chk_a2, pending_q, grf_we_q, grf_a3_q) ||
                  reg_hazard(chk_a3, pending_q, grf_we_q, grf_a3_q);

   a_fifo_count_bound: assert property (
      @(posedge clk) disable iff (!reset) fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;
   import grf_pkg::*;

   localparam int E_W = ADDR_W + 2 * DATA_W;

   logic                clk;
   logic                reset;
   logic                pl_we;
   logic [ADDR_W-1:0]   pl_addr;
   logic [DATA_W-1:0]   pl_wd;
   logic [DATA_W-1:0]   pl_pc;
   logic                md_issue;
   logic [ADDR_W-1:0]   md_issue_addr;
   logic                md_valid;
   logic                md_ready;
   logic [ADDR_W-1:0]   md_addr;
   logic [DATA_W-1:0]   md_wd;
   logic [DATA_W-1:0]   md_pc;
   logic                grf_we;
   logic [ADDR_W-1:0]   grf_a3;
   logic [DATA_W-1:0]   grf_wd;
   logic [DATA_W-1:0]   grf_pc;
   logic [ADDR_W-1:0]   chk_a1;
   logic [ADDR_W-1:0]   chk_a2;
   logic [ADDR_W-1:0]   chk_a3;
   logic                stall;
   logic [NUM_REGS-1:0] pending;

   int errors = 0;
   int checks = 0;
   logic [E_W-1:0] exp_q[$];
   logic [E_W-1:0] mon_got;
   logic [E_W-1:0] mon_want;
   int   md_idx;
   logic fire;

   // contention tables
   logic [ADDR_W-1:0] cont_pl_a  [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
   logic [DATA_W-1:0] cont_pl_wd [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
   logic [DATA_W-1:0] cont_pl_pc [4] = '{32'h3100, 32'h3104, 32'h3108, 32'h310C};
   logic [ADDR_W-1:0] cont_md_a  [3] = '{5'd10, 5'd11, 5'd13};
   logic [DATA_W-1:0] cont_md_wd [3] = '{32'hA10, 32'hA11, 32'hA13};
   logic [DATA_W-1:0] cont_md_pc [3] = '{32'h3200, 32'h3204, 32'h3208};

   grf_wb_arbiter #(.FIFO_DEPTH(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .pl_we         (pl_we),
      .pl_addr       (pl_addr),
      .pl_wd         (pl_wd),
      .pl_pc         (pl_pc),
      .md_issue      (md_issue),
      .md_issue_addr (md_issue_addr),
      .md_valid      (md_valid),
      .md_ready      (md_ready),
      .md_addr       (md_addr),
      .md_wd         (md_wd),
      .md_pc         (md_pc),
      .grf_we        (grf_we),
      .grf_a3        (grf_a3),
      .grf_wd        (grf_wd),
      .grf_pc        (grf_pc),
      .chk_a1        (chk_a1),
      .chk_a2        (chk_a2),
      .chk_a3        (chk_a3),
      .stall         (stall),
      .pending       (pending)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                            input logic [DATA_W-1:0] pc);
      exp_q.push_back({a, wd, pc});
   endtask

   task automatic drive_pl(input logic we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] pc);
      pl_we = we; pl_addr = a; pl_wd = wd; pl_pc = pc;
   endtask

   task automatic drive_md(input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] pc);
      md_valid = v; md_addr = a; md_wd = wd; md_pc = pc;
   endtask

   // monitor: every GRF write must match the head of the expected queue
   always @(negedge clk) begin
      if (reset === 1'b1 && grf_we === 1'b1) begin
         checks++;
         mon_got = {grf_a3, grf_wd, grf_pc};
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL grf_write_unexpected: got a3=%0d wd=%0h pc=%0h expected none",
                     grf_a3, grf_wd, grf_pc);
         end else begin
            mon_want = exp_q.pop_front();
            if (mon_got !== mon_want) begin
               errors++;
               $display("FAIL grf_write: got %0h expected %0h", mon_got, mon_want);
            end
         end
      end
   end

   // issuing to a register that is already pending is illegal
   always @(posedge clk) begin
      if (reset === 1'b1 && md_issue === 1'b1 && md_issue_addr != REG_ZERO) begin
         checks++;
         assert (pending[md_issue_addr] == 1'b0) else begin
            errors++;
            $display("FAIL issue_to_pending: got pending[%0d]=1 expected 0", md_issue_addr);
         end
      end
   end

   initial begin
      reset = 1'b0;
      drive_pl(1'b0, '0, '0, '0);
      drive_md(1'b0, '0, '0, '0);
      md_issue = 1'b0; md_issue_addr = '0;
      chk_a1 = '0; chk_a2 = '0; chk_a3 = '0;

      // reset state
      tick(); tick();
      check("rst_md_ready", 64'(md_ready), 64'(0));
      check("rst_grf_we",   64'(grf_we),   64'(0));
      check("rst_grf_a3",   64'(grf_a3),   64'(0));
      check("rst_grf_wd",   64'(grf_wd),   64'(0));
      check("rst_pending",  64'(pending),  64'(0));
      reset = 1'b1;
      #1;
      check("rel_md_ready", 64'(md_ready), 64'(1));

      // pipeline-only write
      drive_pl(1'b1, 5'd8, 32'h1234, 32'h3000);
      expect_wr(5'd8, 32'h1234, 32'h3000);
      tick();
      drive_pl(1'b0, '0, '0, '0);
      check("pl_grf_we",   64'(grf_we),   64'(1));
      check("pl_grf_a3",   64'(grf_a3),   64'(8));
      check("pl_md_ready", 64'(md_ready), 64'(1));
      tick();
      check("pl_we_drop",  64'(grf_we),   64'(0));

      // MDU through idle port
      md_issue = 1'b1; md_issue_addr = 5'd9;
      tick();
      md_issue = 1'b0; md_issue_addr = '0;
      check("md_pending9", 64'(pending), 64'h200);
      chk_a1 = 5'd9;
      #1;
      check("md_stall_pend", 64'(stall), 64'(1));
      drive_md(1'b1, 5'd9, 32'hCAFE, 32'h3004);
      expect_wr(5'd9, 32'hCAFE, 32'h3004);
      check("md_ready_idle", 64'(md_ready), 64'(1));
      tick();                                   // push
      drive_md(1'b0, '0, '0, '0);
      check("md_no_wr_yet", 64'(grf_we), 64'(0));
      check("md_stall_buf", 64'(stall),  64'(1));
      tick();                                   // pop
      check("md_wr_we",      64'(grf_we),     64'(1));
      check("md_wr_a3",      64'(grf_a3),     64'(9));
      check("md_pend_clr",   64'(pending[9]), 64'(0));
      check("md_stall_fly",  64'(stall),      64'(1));
      tick();
      check("md_stall_done", 64'(stall),      64'(0));
      chk_a1 = '0;

      // contention: pipeline holds the port for 4 cycles
      for (int i = 0; i < 4; i++) expect_wr(cont_pl_a[i], cont_pl_wd[i], cont_pl_pc[i]);
      for (int i = 0; i < 3; i++) expect_wr(cont_md_a[i], cont_md_wd[i], cont_md_pc[i]);
      md_idx = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc < 4) drive_pl(1'b1, cont_pl_a[cyc], cont_pl_wd[cyc], cont_pl_pc[cyc]);
         else         drive_pl(1'b0, '0, '0, '0);
         if (md_idx < 3) drive_md(1'b1, cont_md_a[md_idx], cont_md_wd[md_idx], cont_md_pc[md_idx]);
         else            drive_md(1'b0, '0, '0, '0);
         #1;
         if (cyc < 4)  check($sformatf("cont_ready_%0d", cyc), 64'(md_ready), (cyc < 2) ? 64'(1) : 64'(0));
         if (cyc == 4) check("cont_ready_full", 64'(md_ready), 64'(0));
         if (cyc == 5) check("cont_ready_free", 64'(md_ready), 64'(1));
         fire = md_valid && md_ready;
         tick();
         if (fire) md_idx++;
      end
      check("cont_all_pushed", 64'(md_idx),       64'(3));
      check("cont_drained",    64'(exp_q.size()), 64'(0));

      // zero register
      drive_pl(1'b1, 5'd5, 32'h55, 32'h4000);
      drive_md(1'b1, 5'd14, 32'hE0E0, 32'h4004);
      md_issue = 1'b1; md_issue_addr = '0;
      expect_wr(5'd5, 32'h55, 32'h4000);
      expect_wr(5'd14, 32'hE0E0, 32'h4004);
      tick();
      md_issue = 1'b0;
      drive_md(1'b0, '0, '0, '0);
      check("zero_issue_ignored", 64'(pending), 64'(0));
      drive_pl(1'b1, 5'd0, 32'hDEAD, 32'h4008);
      tick();
      check("zero_pl_pop_we", 64'(grf_we), 64'(1));
      check("zero_pl_pop_a3", 64'(grf_a3), 64'(14));
      drive_pl(1'b0, '0, '0, '0);
      drive_md(1'b1, 5'd0, 32'hBAD, 32'h400C);
      #1;
      check("zero_push_ready", 64'(md_ready), 64'(1));
      tick();
      drive_md(1'b0, '0, '0, '0);
      check("zero_push_idle1", 64'(grf_we), 64'(0));
      tick();
      check("zero_push_idle2", 64'(grf_we), 64'(0));
      md_issue = 1'b1; md_issue_addr = 5'd15;
      tick();
      md_issue = 1'b0; md_issue_addr = '0;
      #1;
      check("zero_chk_nostall", 64'(stall), 64'(0));
      chk_a2 = 5'd15;
      #1;
      check("rt_chk_stall", 64'(stall), 64'(1));
      drive_md(1'b1, 5'd15, 32'hF15, 32'h4010);
      expect_wr(5'd15, 32'hF15, 32'h4010);
      tick();
      drive_md(1'b0, '0, '0, '0);
      tick();
      tick();
      check("rt_chk_release", 64'(stall), 64'(0));
      chk_a2 = '0;

      // async reset mid-operation
      md_issue = 1'b1; md_issue_addr = 5'd10;
      tick();
      md_issue_addr = 5'd11;
      tick();
      md_issue = 1'b0; md_issue_addr = '0;
      drive_pl(1'b1, 5'd6, 32'h66, 32'h5000);
      drive_md(1'b1, 5'd10, 32'hA0, 32'h5004);
      expect_wr(5'd6, 32'h66, 32'h5000);
      tick();
      drive_pl(1'b1, 5'd7, 32'h77, 32'h5008);
      drive_md(1'b1, 5'd11, 32'hB0, 32'h500C);
      #1;
      check("rst_mid_ready1", 64'(md_ready), 64'(1));
      tick();
      drive_pl(1'b0, '0, '0, '0);
      drive_md(1'b0, '0, '0, '0);
      check("rst_mid_pending", 64'(pending), 64'h0C00);
      check("rst_mid_full",    64'(md_ready), 64'(0));
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("rst_mid_we",      64'(grf_we),   64'(0));
      check("rst_mid_a3",      64'(grf_a3),   64'(0));
      check("rst_mid_wd",      64'(grf_wd),   64'(0));
      check("rst_mid_pc",      64'(grf_pc),   64'(0));
      check("rst_mid_pend0",   64'(pending),  64'(0));
      check("rst_mid_ready0",  64'(md_ready), 64'(0));
      tick(); tick();
      reset = 1'b1;
      #1;
      check("rst_rel_ready", 64'(md_ready), 64'(1));
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("rst_no_write_%0d", i), 64'(grf_we), 64'(0));
      end
      check("rst_rel_pending", 64'(pending), 64'(0));

      // WAW on the destination
      md_issue = 1'b1; md_issue_addr = 5'd12;
      tick();
      md_issue = 1'b0; md_issue_addr = '0;
      chk_a3 = 5'd12;
      #1;
      check("waw_stall_pend", 64'(stall), 64'(1));
      drive_md(1'b1, 5'd12, 32'hC12, 32'h6000);
      expect_wr(5'd12, 32'hC12, 32'h6000);
      tick();
      drive_md(1'b0, '0, '0, '0);
      check("waw_stall_buf", 64'(stall), 64'(1));
      tick();
      check("waw_commit_we",  64'(grf_we), 64'(1));
      check("waw_stall_fly",  64'(stall),  64'(1));
      tick();
      check("waw_stall_done", 64'(stall),  64'(0));
      chk_a3 = '0;

      tick(); tick(); tick();
      check("queue_drained", 64'(exp_q.size()), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
